// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: FSM encoding, header bytes
// and the default payload limit.
package uart_frame_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HDR1 = 3'd1,
    ST_GET_LEN   = 3'd2,
    ST_GET_CMD   = 3'd3,
    ST_GET_DATA  = 3'd4,
    ST_GET_SUM   = 3'd5
  } state_t;

  localparam logic [7:0] HDR0_DEF    = 8'h55;
  localparam logic [7:0] HDR1_DEF    = 8'hAA;
  localparam int         MAX_LEN_DEF = 16;
  localparam int         BUF_DEPTH   = 16;

endpackage

// File: rtl/uart_frame_parser_frame_buf.sv
// Payload buffer: 16x8 register file, one synchronous write port and one
// combinational read port. Cleared by reset.
module uart_frame_parser_frame_buf
  import uart_frame_parser_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [BUF_DEPTH-1:0][7:0] mem_q;
  logic [BUF_DEPTH-1:0][7:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses HDR0 HDR1 LEN CMD payload SUM frames from a UART byte stream,
// stores the payload and reports good frames or one of three error pulses.
//
// state        | meaning
// ST_IDLE      | hunting for HDR0
// ST_WAIT_HDR1 | HDR0 seen, expecting HDR1 (HDR0 again resyncs)
// ST_GET_LEN   | expecting payload length
// ST_GET_CMD   | expecting command byte
// ST_GET_DATA  | collecting LEN payload bytes into the buffer
// ST_GET_SUM   | expecting checksum byte
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int         MAX_LEN = MAX_LEN_DEF,
  parameter int         TIMEOUT = 50000,
  parameter logic [7:0] HDR0    = HDR0_DEF,
  parameter logic [7:0] HDR1    = HDR1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_din,
  input  logic       rx_vld,
  output logic       frm_vld,
  output logic [7:0] frm_cmd,
  output logic [4:0] frm_len,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       err_sum,
  output logic       err_len,
  output logic       err_tout
);

  localparam int             CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TC = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [4:0]    len_q, len_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    sum_q, sum_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    frm_cmd_q, frm_cmd_d;
  logic [4:0]    frm_len_q, frm_len_d;
  logic          frm_vld_q, frm_vld_d;
  logic          err_sum_q, err_sum_d;
  logic          err_len_q, err_len_d;
  logic          err_tout_q, err_tout_d;
  logic          wr_en;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cmd_d      = cmd_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    frm_cmd_d  = frm_cmd_q;
    frm_len_d  = frm_len_q;
    frm_vld_d  = 1'b0;
    err_sum_d  = 1'b0;
    err_len_d  = 1'b0;
    err_tout_d = 1'b0;
    wr_en      = 1'b0;

    // A byte arriving on the terminal count wins over the timeout.
    if (state_q == ST_IDLE || rx_vld) begin
      cnt_d = '0;
    end else if (cnt_q == TC) begin
      cnt_d      = '0;
      err_tout_d = 1'b1;
      state_d    = ST_IDLE;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (rx_vld) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_din == HDR0) state_d = ST_WAIT_HDR1;
        end
        ST_WAIT_HDR1: begin
          if (rx_din == HDR1)      state_d = ST_GET_LEN;
          else if (rx_din != HDR0) state_d = ST_IDLE;
        end
        ST_GET_LEN: begin
          if (rx_din > 8'(MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            len_d   = rx_din[4:0];
            sum_d   = rx_din;
            idx_d   = '0;
            state_d = ST_GET_CMD;
          end
        end
        ST_GET_CMD: begin
          cmd_d   = rx_din;
          sum_d   = sum_q + rx_din;
          state_d = (len_q != 5'd0) ? ST_GET_DATA : ST_GET_SUM;
        end
        ST_GET_DATA: begin
          wr_en = 1'b1;
          sum_d = sum_q + rx_din;
          idx_d = idx_q + 4'd1;
          if ({1'b0, idx_q} == len_q - 5'd1) state_d = ST_GET_SUM;
        end
        ST_GET_SUM: begin
          if (rx_din == sum_q) begin
            frm_vld_d = 1'b1;
            frm_cmd_d = cmd_q;
            frm_len_d = len_q;
          end else begin
            err_sum_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cmd_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      frm_cmd_q  <= '0;
      frm_len_q  <= '0;
      frm_vld_q  <= 1'b0;
      err_sum_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_tout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      frm_cmd_q  <= frm_cmd_d;
      frm_len_q  <= frm_len_d;
      frm_vld_q  <= frm_vld_d;
      err_sum_q  <= err_sum_d;
      err_len_q  <= err_len_d;
      err_tout_q <= err_tout_d;
    end
  end

  uart_frame_parser_frame_buf frame_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (idx_q),
    .wr_data (rx_din),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign frm_vld  = frm_vld_q;
  assign frm_cmd  = frm_cmd_q;
  assign frm_len  = frm_len_q;
  assign err_sum  = err_sum_q;
  assign err_len  = err_len_q;
  assign err_tout = err_tout_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: table of frames plus hand
// sequences for timeout and mid-frame reset, with an event scoreboard.
module tb_uart_frame_parser;

  localparam int T = 20;
  localparam logic [3:0] EV_VLD  = 4'b1000;
  localparam logic [3:0] EV_SUM  = 4'b0100;
  localparam logic [3:0] EV_LEN  = 4'b0010;
  localparam logic [3:0] EV_TOUT = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_din;
  logic       rx_vld;
  logic       frm_vld;
  logic [7:0] frm_cmd;
  logic [4:0] frm_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       err_sum;
  logic       err_len;
  logic       err_tout;

  uart_frame_parser #(.TIMEOUT(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_din   (rx_din),
    .rx_vld   (rx_vld),
    .frm_vld  (frm_vld),
    .frm_cmd  (frm_cmd),
    .frm_len  (frm_len),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .err_sum  (err_sum),
    .err_len  (err_len),
    .err_tout (err_tout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [23:0][7:0] b;
    int               n;
    int               gap;
    int               off;
    logic [3:0]       ev;
    logic [7:0]       cmd;
    logic [4:0]       len;
  } vec_t;

  typedef struct packed {
    logic [3:0] ev;
    logic [7:0] cmd;
    logic [4:0] len;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_ent;
  logic [3:0] mon_ev;
  vec_t       vecs[9];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] last_cmd;
  logic [4:0] last_len;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  function automatic vec_t mk(input logic [191:0] raw, input int n, input int gap,
                              input int off, input logic [3:0] ev,
                              input logic [7:0] cmd, input logic [4:0] len);
    vec_t v;
    v = '0;
    v.n = n; v.gap = gap; v.off = off; v.ev = ev; v.cmd = cmd; v.len = len;
    for (int i = 0; i < n; i++) v.b[i] = raw[8*(n-1-i) +: 8];
    return v;
  endfunction

  function automatic vec_t mk_max();
    vec_t       v;
    logic [7:0] s;
    v = '0;
    v.b[0] = 8'h55; v.b[1] = 8'hAA; v.b[2] = 8'h10; v.b[3] = 8'h77;
    s = 8'h10 + 8'h77;
    for (int i = 0; i < 16; i++) begin
      v.b[4+i] = 8'(i * 3 + 1);
      s = s + v.b[4+i];
    end
    v.b[20] = s;
    v.n = 21; v.gap = 0; v.off = 4; v.ev = EV_VLD; v.cmd = 8'h77; v.len = 5'd16;
    return v;
  endfunction

  // Every output pulse must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    mon_ev = {frm_vld, err_sum, err_len, err_tout};
    if (mon_ev != 4'b0) begin
      chk("pulse_onehot", $countones(mon_ev), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {28'b0, mon_ev}, 0);
      end else begin
        mon_ent = exp_q.pop_front();
        chk("pulse_kind", {28'b0, mon_ev}, {28'b0, mon_ent.ev});
        chk("pulse_cycle", cyc, mon_ent.cyc);
        if (mon_ent.ev == EV_VLD) begin
          chk("frm_cmd_at_vld", {24'b0, frm_cmd}, {24'b0, mon_ent.cmd});
          chk("frm_len_at_vld", {27'b0, frm_len}, {27'b0, mon_ent.len});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_din = b;
    rx_vld = 1'b1;
    @(posedge clk);
    #1;
    rx_vld = 1'b0;
    rx_din = 8'($urandom);
  endtask

  task automatic push_exp(input logic [3:0] ev, input logic [7:0] cmd,
                          input logic [4:0] len, input int at);
    exp_t e;
    e.ev = ev; e.cmd = cmd; e.len = len; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int lim);
    int k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      if (i > 0) idle(v.gap);
      drive_byte(v.b[i]);
    end
    if (v.ev != 4'b0) push_exp(v.ev, v.cmd, v.len, cyc);
    wait_drain(T + 10);
    if (v.ev == EV_VLD) begin
      last_cmd = v.cmd;
      last_len = v.len;
    end
    chk("frm_cmd_hold", {24'b0, frm_cmd}, {24'b0, last_cmd});
    chk("frm_len_hold", {27'b0, frm_len}, {27'b0, last_len});
    if (v.ev == EV_VLD) begin
      for (int i = 0; i < int'(v.len); i++) begin
        rd_addr = 4'(i);
        #1;
        chk("rd_data", {24'b0, rd_data}, {24'b0, v.b[v.off+i]});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(192'h55AA031001020319, 8, 0, 4, EV_VLD, 8'h10, 5'd3);
    vecs[1] = mk(192'h55AA031001020318, 8, 0, 4, EV_SUM, 8'h00, 5'd0);
    vecs[2] = mk(192'h55AA11, 3, 0, 0, EV_LEN, 8'h00, 5'd0);
    vecs[3] = mk(192'h55AA0244_0A0B5B, 7, 0, 4, EV_VLD, 8'h44, 5'd2);
    vecs[4] = mk(192'h5555AA002020, 6, 0, 4, EV_VLD, 8'h20, 5'd0);
    vecs[5] = mk(192'h12553455AA01300536, 9, 0, 7, EV_VLD, 8'h30, 5'd1);
    vecs[6] = mk(192'h55AA01310537, 6, T - 1, 4, EV_VLD, 8'h31, 5'd1);
    vecs[7] = mk_max();
    vecs[8] = mk(192'h55AA002021, 5, 0, 0, EV_SUM, 8'h00, 5'd0);

    rst = 1'b1; rx_vld = 1'b0; rx_din = 8'h00; rd_addr = 4'd0;
    last_cmd = 8'h00; last_len = 5'd0;
    idle(3);
    chk("reset_pulses", {28'b0, frm_vld, err_sum, err_len, err_tout}, 0);
    chk("reset_frm_cmd", {24'b0, frm_cmd}, 0);
    chk("reset_frm_len", {27'b0, frm_len}, 0);
    chk("reset_rd_data", {24'b0, rd_data}, 0);
    rst = 1'b0;
    idle(2);

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    // Stalled frame after LEN: timeout exactly T cycles after the last strobe.
    drive_byte(8'h55);
    drive_byte(8'hAA);
    drive_byte(8'h02);
    push_exp(EV_TOUT, 8'h00, 5'd0, cyc + T);
    wait_drain(T + 10);
    chk("frm_cmd_after_tout", {24'b0, frm_cmd}, {24'b0, last_cmd});
    run_vec(vecs[3]);

    // Reset mid-frame: everything clears silently, then a fresh frame works.
    drive_byte(8'h55);
    drive_byte(8'hAA);
    drive_byte(8'h03);
    drive_byte(8'h10);
    drive_byte(8'h01);
    rst = 1'b1;
    rd_addr = 4'd0;
    #1;
    chk("midrst_pulses", {28'b0, frm_vld, err_sum, err_len, err_tout}, 0);
    chk("midrst_frm_cmd", {24'b0, frm_cmd}, 0);
    chk("midrst_frm_len", {27'b0, frm_len}, 0);
    chk("midrst_rd_data", {24'b0, rd_data}, 0);
    idle(2);
    rst = 1'b0;
    last_cmd = 8'h00;
    last_len = 5'd0;
    idle(T + 5);
    run_vec(vecs[0]);

    chk("no_leftover_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload bytes per frame, range 1..16.
REQ-002 SHALL have parameter TIMEOUT, default 50000: idle clock cycles between bytes that abort a frame in progress.
REQ-003 SHALL have parameters HDR0 = 8'h55 and HDR1 = 8'hAA: the two header bytes.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port rx_din, input, 8: received byte from the upstream UART receiver.
REQ-007 SHALL have port rx_vld, input, 1: one-cycle strobe qualifying rx_din.
REQ-008 SHALL have port frm_vld, output, 1: one-cycle pulse marking a good frame.
REQ-009 SHALL have port frm_cmd, output, 8: command byte of the last good frame.
REQ-010 SHALL have port frm_len, output, 5: payload length of the last good frame.
REQ-011 SHALL have port rd_addr, input, 4: payload buffer read address.
REQ-012 SHALL have port rd_data, output, 8: payload byte at rd_addr; combinational read.
REQ-013 SHALL have ports err_sum, err_len and err_tout, each output, 1: one-cycle error pulses.

Function
REQ-014 SHALL use frame format HDR0, HDR1, LEN, CMD, LEN payload bytes, SUM.
REQ-015 SHALL define SUM as the modulo-256 sum of LEN, CMD and all payload bytes.
REQ-016 SHALL implement FSM states IDLE, WAIT_HDR1, GET_LEN, GET_CMD, GET_DATA and GET_SUM; each state advances only on rx_vld.
REQ-017 SHALL make these transitions:
- IDLE to WAIT_HDR1 on byte HDR0; any other byte stays in IDLE.
- WAIT_HDR1 to GET_LEN on HDR1; stays on HDR0 (resync); goes to IDLE on anything else.
REQ-018 SHALL, in GET_LEN:
- LEN > MAX_LEN: pulse err_len and go to IDLE.
- Otherwise: latch LEN, clear the running sum, add LEN, go to GET_CMD.
REQ-019 SHALL, in GET_CMD:
- latch CMD and add it to the sum;
- go to GET_DATA if LEN > 0, else to GET_SUM.
REQ-020 SHALL, in GET_DATA:
- write each byte to buffer[idx] and add it to the sum;
- idx starts at 0 and increments per byte;
- after byte LEN-1, go to GET_SUM.
REQ-021 SHALL, in GET_SUM:
- byte equal to the running sum: frm_vld=1, frm_cmd/frm_len updated, in the next cycle;
- byte not equal: err_sum=1 in the next cycle;
- either way, go to IDLE.
REQ-022 SHALL hold frm_cmd and frm_len until the next good frame; a bad frame leaves them unchanged.
REQ-023 SHALL treat the payload buffer as 16x8 registers:
- overwritten by a later frame's GET_DATA bytes, good or bad;
- rd_data undefined for rd_addr >= frm_len.
REQ-024 SHALL run an inter-byte counter in every state except IDLE:
- cleared on each rx_vld and on entering IDLE;
- on reaching TIMEOUT-1 without rx_vld: pulse err_tout and go to IDLE.
REQ-025 SHALL give rx_vld priority over timeout when both occur in the same cycle: the byte is accepted and the counter is cleared.
REQ-026 SHALL ignore rx_din whenever rx_vld is low; back-to-back rx_vld on consecutive cycles SHALL be accepted.
REQ-027 SHALL assert at most one of frm_vld, err_sum, err_len and err_tout in any cycle.

Reset
REQ-028 SHALL, while rst is high:
- force the FSM to IDLE;
- clear all counters, the sum, idx, frm_cmd, frm_len and the buffer to 0;
- drive frm_vld and all err_* outputs to 0.
REQ-029 SHALL, when rst is asserted mid-frame, discard the frame with no error pulse; the next HDR0 after release starts a fresh frame.

Structure
REQ-030 SHALL keep the FSM state encodings, HDR0/HDR1 and the MAX_LEN default in the shared uart package.
REQ-031 SHALL instantiate one sub-module, frame_buf (16x8 register file, one write port, one async read port); all other logic stays inline.

Verification
REQ-032 SHALL cover: 55 AA 03 10 01 02 03 19 -> frm_vld one cycle after the last byte, frm_cmd=0x10, frm_len=3, rd_data[0..2]=01,02,03.
REQ-033 SHALL cover: the same frame with SUM 0x18 -> err_sum pulse, no frm_vld, frm_cmd/frm_len keep their prior values.
REQ-034 SHALL cover: 55 AA 11 -> err_len pulse, FSM returns to IDLE; a following good frame is accepted.
REQ-035 SHALL cover: 55 55 AA 00 20 20 -> resync on the repeated 55, frm_vld with frm_cmd=0x20, frm_len=0.
REQ-036 SHALL cover: 55 AA 02, then no rx_vld -> err_tout exactly TIMEOUT cycles after the 02 strobe.
REQ-037 SHALL cover: rst pulsed after 55 AA 03 10 01 -> all outputs 0, no error pulse; a subsequent complete good frame gives frm_vld.
